multiplier_factor_search: RTL and testbench
===========================================

MULTIPLIER_FACTOR_SEARCH -- requirements
Module: multiplier_factor_search

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset (already decided); all other ports are synchronous to rising clk.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have port: start  input  1  search request, sampled only in IDLE.
REQ-005 SHALL have port: target  input  13  product to factor, captured on start accept.
REQ-006 SHALL have port: busy  output  1  high while in SCAN.
REQ-007 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-008 SHALL have port: sat  output  1  high if a nontrivial factor pair was found.
REQ-009 SHALL have port: a_out  output  8  factor a, range 2..255.
REQ-010 SHALL have port: b_out  output  5  factor b, range 2..31.

Function
REQ-011 SHALL implement the states IDLE, SCAN and DONE; no other reachable states.
REQ-012 IDLE with start=1 at an edge SHALL capture target into tgt and set b=2, a=2, acc=4, then go to SCAN.
REQ-013 Start SHALL be ignored in SCAN and DONE; target changes after capture SHALL have no effect.
REQ-014 On entry to SCAN, sat, a_out and b_out SHALL clear to 0.
REQ-015 SCAN, per cycle, priority 1: acc==tgt -> a_out=a, b_out=b, sat=1, go to DONE.
REQ-016 SCAN, priority 2: acc>tgt or a==255 -> if b==31 then sat=0, go to DONE; else b=b+1, a=2, acc=2*(b+1).
REQ-017 SCAN, priority 3: a=a+1, acc=acc+b.
REQ-018 acc SHALL be 13 bits unsigned; the maximum reachable value is 255*31=7905, so no overflow occurs; comparisons SHALL be unsigned.
REQ-019 Enumeration order SHALL be b outer ascending and a inner ascending; the reported pair SHALL have the smallest valid b.
REQ-020 Trivial factors (a or b equal to 0 or 1) SHALL never be reported.
REQ-021 Targets below 4 SHALL scan every b for 1 cycle each (30 cycles) and report sat=0.
REQ-022 DONE SHALL last exactly one cycle with done=1, then go to IDLE.
REQ-023 busy SHALL be 1 exactly in SCAN and done SHALL be 1 exactly in DONE.
REQ-024 sat, a_out and b_out SHALL hold from DONE until the next start accept.
REQ-025 A start presented in the same cycle the block returns from DONE to IDLE SHALL NOT be accepted; it is accepted only when sampled in IDLE.
REQ-026 The number of SCAN cycles SHALL equal the number of (b, a) candidates visited; there are no stall or idle cycles inside SCAN.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE and busy=0, done=0, sat=0, a_out=0, b_out=0, tgt=0, a=0, b=0, acc=0, independent of clk.
REQ-028 rst asserted mid-SCAN SHALL abort the search with no done pulse; the first start after rst deasserts SHALL begin a fresh search.
REQ-029 After rst deasserts, the block SHALL accept a start on the first clock edge.

Verification
REQ-030 target=6, start pulse -> 2 SCAN cycles, then done=1 for one cycle with sat=1, b_out=2, a_out=3.
REQ-031 target=307 (prime) -> 914 SCAN cycles, then done=1 with sat=0, a_out=0, b_out=0.
REQ-032 target=7905 -> sat=1, b_out=31, a_out=255 (boundary values for both factors).
REQ-033 target=8191 -> every b exits via a==255; 30*254=7620 SCAN cycles; sat=0.
REQ-034 target=3 -> 30 SCAN cycles then sat=0; start held high continuously -> a new search begins one cycle after each IDLE, with exactly one done pulse per search.
REQ-035 rst pulsed 100 cycles into the search for target=307 -> all outputs 0 immediately and no done pulse; a subsequent target=15 search -> sat=1, b_out=3, a_out=5.

Source files
------------

// File: rtl/multiplier_factor_search.sv
// Searches for the factor pair b*a == target, with b in 2..31 (outer, ascending) and a in 2..255 (inner).
// It tests one (b, a) candidate per SCAN cycle, so the cycle count equals the number of candidates visited.
module multiplier_factor_search (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [12:0] target,
    output logic        busy,
    output logic        done,
    output logic        sat,
    output logic [7:0]  a_out,
    output logic [4:0]  b_out
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t      state_q, state_d;
    logic [12:0] tgt_q, tgt_d;
    logic [12:0] acc_q, acc_d;
    logic [7:0]  a_q, a_d;
    logic [4:0]  b_q, b_d;
    logic        sat_q, sat_d;
    logic [7:0]  aout_q, aout_d;
    logic [4:0]  bout_q, bout_d;
    logic [4:0]  b_inc;

    assign b_inc = b_q + 5'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sat_q   <= 1'b0;
            aout_q  <= '0;
            bout_q  <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sat_q   <= sat_d;
            aout_q  <= aout_d;
            bout_q  <= bout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        sat_d   = sat_q;
        aout_d  = aout_q;
        bout_d  = bout_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    tgt_d   = target;
                    b_d     = 5'd2;
                    a_d     = 8'd2;
                    acc_d   = 13'd4;
                    sat_d   = 1'b0;
                    aout_d  = '0;
                    bout_d  = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                // acc always holds a*b for the current candidate
                if (acc_q == tgt_q) begin
                    aout_d  = a_q;
                    bout_d  = b_q;
                    sat_d   = 1'b1;
                    state_d = DONE;
                end else if ((acc_q > tgt_q) || (a_q == 8'd255)) begin
                    if (b_q == 5'd31) begin
                        sat_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        b_d   = b_inc;
                        a_d   = 8'd2;
                        acc_d = {7'd0, b_inc, 1'b0};
                    end
                end else begin
                    a_d   = a_q + 8'd1;
                    acc_d = acc_q + {8'd0, b_q};
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy  = (state_q == SCAN);
    assign done  = (state_q == DONE);
    assign sat   = sat_q;
    assign a_out = aout_q;
    assign b_out = bout_q;

endmodule

// File: tb/tb_multiplier_factor_search.sv
// Bench for multiplier_factor_search: a table of targets with expected results, plus hand-written reset and held-start sequences.
module tb_multiplier_factor_search;

    logic        clk;
    logic        rst;
    logic        start;
    logic [12:0] target;
    logic        busy;
    logic        done;
    logic        sat;
    logic [7:0]  a_out;
    logic [4:0]  b_out;

    typedef struct {
        int tgt;
        int sat;
        int a;
        int b;
        int cycles;
    } vec_t;

    vec_t vecs[9];
    vec_t sb[$];

    int n_vec = 0;
    int n_err = 0;
    int done_count = 0;
    int scan_cnt = 0;
    bit prev_done = 0;

    multiplier_factor_search dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .target(target),
        .busy  (busy),
        .done  (done),
        .sat   (sat),
        .a_out (a_out),
        .b_out (b_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: walk the candidates in order and count them.
    function automatic vec_t model(input int t);
        vec_t r;
        r.tgt = t; r.sat = 0; r.a = 0; r.b = 0; r.cycles = 0;
        for (int bb = 2; bb <= 31; bb++) begin
            for (int aa = 2; aa <= 255; aa++) begin
                r.cycles++;
                if (aa * bb == t) begin
                    r.sat = 1; r.a = aa; r.b = bb;
                    return r;
                end
                if (aa * bb > t) break;
            end
        end
        return r;
    endfunction

    // Scoreboard monitor: counts SCAN cycles and checks each done pulse against the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                scan_cnt  = 0;
                prev_done = 0;
            end else begin
                if (busy) scan_cnt++;
                if (busy && done) check("busy_and_done", 1, 0);
                if (done) begin
                    done_count++;
                    if (prev_done) check("done_width", 2, 1);
                    if (sb.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        vec_t e;
                        e = sb.pop_front();
                        check($sformatf("sat[t=%0d]", e.tgt), int'(sat), e.sat);
                        check($sformatf("a_out[t=%0d]", e.tgt), int'(a_out), e.a);
                        check($sformatf("b_out[t=%0d]", e.tgt), int'(b_out), e.b);
                        check($sformatf("scan_cycles[t=%0d]", e.tgt), scan_cnt, e.cycles);
                    end
                    scan_cnt = 0;
                end
                prev_done = done;
            end
        end
    end

    task automatic wait_done(input int bound);
        bit ok;
        ok = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1;
                break;
            end
        end
        check("done_seen", int'(ok), 1);
    endtask

    task automatic launch(input vec_t v);
        @(negedge clk);
        target = v.tgt[12:0];
        start  = 1'b1;
        sb.push_back(v);
        @(negedge clk);
        start  = 1'b0;
        target = 13'($urandom);
        check("accepted_busy", int'(busy), 1);
    endtask

    task automatic run_vec(input vec_t v);
        launch(v);
        wait_done(9000);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("hold_sat", int'(sat), v.sat);
            check("hold_a", int'(a_out), v.a);
            check("hold_b", int'(b_out), v.b);
            check("idle_busy", int'(busy), 0);
        end
    endtask

    initial begin
        vecs[0] = '{tgt: 6,    sat: 1, a: 3,   b: 2,  cycles: 2};
        vecs[1] = '{tgt: 307,  sat: 0, a: 0,   b: 0,  cycles: 914};
        vecs[2] = '{tgt: 7905, sat: 1, a: 255, b: 31, cycles: 7620};
        vecs[3] = '{tgt: 8191, sat: 0, a: 0,   b: 0,  cycles: 7620};
        vecs[4] = '{tgt: 3,    sat: 0, a: 0,   b: 0,  cycles: 30};
        vecs[5] = '{tgt: 15,   sat: 1, a: 5,   b: 3,  cycles: 11};
        vecs[6] = '{tgt: 4,    sat: 1, a: 2,   b: 2,  cycles: 1};
        vecs[7] = '{tgt: 0,    sat: 0, a: 0,   b: 0,  cycles: 30};
        vecs[8] = '{tgt: 62,   sat: 1, a: 31,  b: 2,  cycles: 30};

        rst    = 1'b0;
        start  = 1'b0;
        target = '0;
        #2 rst = 1'b1;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_sat", int'(sat), 0);
        check("rst_a", int'(a_out), 0);
        check("rst_b", int'(b_out), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        for (int i = 0; i < 4; i++) run_vec(model(int'($urandom_range(4, 1500))));

        // Reset clears held results immediately, between clock edges.
        run_vec(vecs[5]);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_sat", int'(sat), 0);
        check("async_rst_a", int'(a_out), 0);
        check("async_rst_b", int'(b_out), 0);
        @(negedge clk);
        rst = 1'b0;

        // Abort mid-search: no done pulse, then a fresh search on the first edge after release.
        launch(vecs[1]);
        repeat (99) @(negedge clk);
        check("mid_scan_busy", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_sat", int'(sat), 0);
        check("abort_a", int'(a_out), 0);
        check("abort_b", int'(b_out), 0);
        sb.delete();
        begin
            int dc;
            dc = done_count;
            repeat (3) @(negedge clk);
            rst = 1'b0;
            repeat (10) @(negedge clk);
            check("no_done_after_abort", done_count, dc);
            check("idle_after_abort", int'(busy), 0);
        end
        @(negedge clk);
        rst    = 1'b1;
        @(negedge clk);
        target = 13'd15;
        start  = 1'b1;
        sb.push_back(vecs[5]);
        rst    = 1'b0;
        @(negedge clk);
        start  = 1'b0;
        check("first_edge_accept", int'(busy), 1);
        wait_done(9000);

        // Start held high: one idle cycle between searches, one done per search.
        @(negedge clk);
        target = 13'd3;
        start  = 1'b1;
        for (int k = 0; k < 3; k++) sb.push_back(vecs[4]);
        for (int k = 0; k < 3; k++) begin
            wait_done(200);
            if (k == 2) begin
                start = 1'b0;
            end else begin
                @(negedge clk);
                check("held_idle_busy", int'(busy), 0);
                check("held_idle_done", int'(done), 0);
                @(negedge clk);
                check("held_restart", int'(busy), 1);
            end
        end
        repeat (3) @(negedge clk);
        check("held_stopped", int'(busy), 0);
        check("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
